spm_copy_master: RTL and testbench

- Initiator (master) for the scratchpad-memory slave port: drives M_Data/M_Addr/M_ByteEn/M_We and consumes S_Data.
- Performs a word-granular block copy inside one SPM: read source word, write destination word, repeat for a programmed length.
- Sits between a core-side control register block and a single-ported SPM.
- Lets software offload bulk SPM moves without stalling the pipeline.

---
 rtl/spm_pkg.sv | 32 +++
 rtl/spm_copy_ctrl.sv | 97 +++++++++
 rtl/spm_copy_master.sv | 121 ++++++++++++
 tb/tb_spm_copy_master.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// -----------------------------------------------------------------------------
// spm_pkg
//   Shared definitions for scratchpad-memory (SPM) initiators.
//   - Default widths for SPM word address, data and transfer length
//   - BYTEEN_ALL: byte-enable value for a full-word access at default width
//   - spm_state_t: copy engine FSM states
//   - spm_cmd_t: bus command bundle {data, addr, byteen, we} at default widths
// -----------------------------------------------------------------------------
package spm_pkg;

    localparam int unsigned SPM_ADDR_W = 16;
    localparam int unsigned SPM_DATA_W = 32;
    localparam int unsigned SPM_LEN_W  = 16;

    localparam logic [SPM_DATA_W/8-1:0] BYTEEN_ALL = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPT,
        ST_WRITE,
        ST_DONE
    } spm_state_t;

    typedef struct packed {
        logic [SPM_DATA_W-1:0]   data;
        logic [SPM_ADDR_W-1:0]   addr;
        logic [SPM_DATA_W/8-1:0] byteen;
        logic                    we;
    } spm_cmd_t;

endpackage

// File: rtl/spm_copy_ctrl.sv
// -----------------------------------------------------------------------------
// spm_copy_ctrl
//   Sequencing FSM and remaining-word counter of the SPM copy master.
//   Copy: READ -> CAPT -> WRITE per word. Fill: WRITE only, one word per cycle.
//   Optional feature macro: SPM_COPY_FILL_EN (only affects what drives
//   start_fill in the top; this block always supports fill sequencing).
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   start           start request (honoured only in IDLE)
//   start_fill      fill-mode select, sampled with start
//   len             word count, sampled with start
//   busy, done      status (busy outside IDLE, done pulse in DONE)
//   load            start accepted with non-zero length (latch operands)
//   rd_en           READ cycle: drive read command
//   capt_en         CAPT cycle: capture slave read data
//   wr_en           WRITE cycle: drive write command, advance pointers
// -----------------------------------------------------------------------------
module spm_copy_ctrl
    import spm_pkg::*;
#(
    parameter int unsigned LEN_W = SPM_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             start_fill,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             load,
    output logic             rd_en,
    output logic             capt_en,
    output logic             wr_en
);

    spm_state_t       state_q;
    spm_state_t       state_d;
    logic [LEN_W-1:0] remaining;
    logic             fill_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
            fill_q    <= 1'b0;
        end else if (load) begin
            remaining <= len;
            fill_q    <= start_fill;
        end else if (wr_en) begin
            remaining <= remaining - LEN_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = start_fill ? ST_WRITE : ST_READ;
                    end
                end
            end
            ST_READ:  state_d = ST_CAPT;
            ST_CAPT:  state_d = ST_WRITE;
            ST_WRITE: begin
                // remaining still holds the count including the word being written
                if (remaining > LEN_W'(1)) begin
                    state_d = fill_q ? ST_WRITE : ST_READ;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_DONE);
        rd_en   = (state_q == ST_READ);
        capt_en = (state_q == ST_CAPT);
        wr_en   = (state_q == ST_WRITE);
        load    = (state_q == ST_IDLE) && start && (len != '0);
    end

endmodule

// File: rtl/spm_copy_master.sv
// -----------------------------------------------------------------------------
// spm_copy_master
//   Word-granular block copy inside a single-ported SPM: read src word,
//   capture it, write it to dst, repeat for io_len words (strictly ascending,
//   addresses wrap modulo 2^ADDR_W). Bus outputs are decoded only from
//   registered state, pointers and data; io_S_Data never reaches them
//   combinationally.
//   Optional feature macro: SPM_COPY_FILL_EN adds io_fill/io_pattern; a fill
//   transfer writes io_pattern to every destination word without reading.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   io_start              one-cycle start request (ignored unless idle)
//   io_src, io_dst        source / destination word address
//   io_len                number of words (0 = immediate completion)
//   io_fill, io_pattern   fill select and pattern (SPM_COPY_FILL_EN only)
//   io_busy               transfer in progress (including the done cycle)
//   io_done               one-cycle completion pulse
//   io_M_Data/Addr/ByteEn/We   SPM command
//   io_S_Data             SPM read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module spm_copy_master
    import spm_pkg::*;
#(
    parameter int unsigned ADDR_W = SPM_ADDR_W,
    parameter int unsigned DATA_W = SPM_DATA_W,
    parameter int unsigned LEN_W  = SPM_LEN_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                io_start,
    input  logic [ADDR_W-1:0]   io_src,
    input  logic [ADDR_W-1:0]   io_dst,
    input  logic [LEN_W-1:0]    io_len,
`ifdef SPM_COPY_FILL_EN
    input  logic                io_fill,
    input  logic [DATA_W-1:0]   io_pattern,
`endif
    output logic                io_busy,
    output logic                io_done,
    output logic [DATA_W-1:0]   io_M_Data,
    output logic [ADDR_W-1:0]   io_M_Addr,
    output logic [DATA_W/8-1:0] io_M_ByteEn,
    output logic                io_M_We,
    input  logic [DATA_W-1:0]   io_S_Data
);

    logic              start_fill;
    logic              load;
    logic              rd_en;
    logic              capt_en;
    logic              wr_en;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [DATA_W-1:0] data_reg;

`ifdef SPM_COPY_FILL_EN
    assign start_fill = io_fill;
`else
    assign start_fill = 1'b0;
`endif

    spm_copy_ctrl #(
        .LEN_W (LEN_W)
    ) u_ctrl (
        .clk        (clk),
        .reset      (reset),
        .start      (io_start),
        .start_fill (start_fill),
        .len        (io_len),
        .busy       (io_busy),
        .done       (io_done),
        .load       (load),
        .rd_en      (rd_en),
        .capt_en    (capt_en),
        .wr_en      (wr_en)
    );

    // In fill mode the pattern is parked in data_reg at start; CAPT never
    // occurs, so the write path is shared with the copy path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_ptr  <= '0;
            dst_ptr  <= '0;
            data_reg <= '0;
        end else begin
            if (load) begin
                src_ptr <= io_src;
                dst_ptr <= io_dst;
`ifdef SPM_COPY_FILL_EN
                if (io_fill) begin
                    data_reg <= io_pattern;
                end
`endif
            end
            if (capt_en) begin
                data_reg <= io_S_Data;
            end
            if (wr_en) begin
                src_ptr <= src_ptr + ADDR_W'(1);
                dst_ptr <= dst_ptr + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        io_M_Data   = '0;
        io_M_Addr   = '0;
        io_M_ByteEn = '0;
        io_M_We     = 1'b0;
        if (rd_en) begin
            io_M_Addr   = src_ptr;
            io_M_ByteEn = '1;
        end else if (wr_en) begin
            io_M_Addr   = dst_ptr;
            io_M_ByteEn = '1;
            io_M_We     = 1'b1;
            io_M_Data   = data_reg;
        end
    end

endmodule

// File: tb/tb_spm_copy_master.sv
// -----------------------------------------------------------------------------
// tb_spm_copy_master
//   Self-checking bench for spm_copy_master with a behavioural SPM and a
//   word-by-word reference copy model. Define SPM_COPY_FILL_EN to also
//   exercise fill mode.
// -----------------------------------------------------------------------------
module tb_spm_copy_master;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        io_start = 1'b0;
    logic [15:0] io_src = '0;
    logic [15:0] io_dst = '0;
    logic [15:0] io_len = '0;
`ifdef SPM_COPY_FILL_EN
    logic        io_fill = 1'b0;
    logic [31:0] io_pattern = '0;
`endif
    logic        io_busy;
    logic        io_done;
    logic [31:0] io_M_Data;
    logic [15:0] io_M_Addr;
    logic [3:0]  io_M_ByteEn;
    logic        io_M_We;
    logic [31:0] io_S_Data;

    int n_cmp = 0;
    int n_bad = 0;

    bit [31:0]   mem     [65536];
    bit [31:0]   ref_mem [65536];
    bit          mem_ready = 1'b0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          done_cnt = 0;
    int          cmd_err = 0;
    logic [15:0] rd_addr_q [$];

    spm_copy_master #(
        .ADDR_W (16),
        .DATA_W (32),
        .LEN_W  (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .io_start    (io_start),
        .io_src      (io_src),
        .io_dst      (io_dst),
        .io_len      (io_len),
`ifdef SPM_COPY_FILL_EN
        .io_fill     (io_fill),
        .io_pattern  (io_pattern),
`endif
        .io_busy     (io_busy),
        .io_done     (io_done),
        .io_M_Data   (io_M_Data),
        .io_M_Addr   (io_M_Addr),
        .io_M_ByteEn (io_M_ByteEn),
        .io_M_We     (io_M_We),
        .io_S_Data   (io_S_Data)
    );

    always #5 clk = ~clk;

    function automatic bit [31:0] init_word(input int unsigned i);
        return (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Single-ported SPM: write on We, registered read data one cycle later,
    // junk on the read-data bus whenever no read was issued.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (io_M_We) begin
            mem[io_M_Addr] <= io_M_Data;
        end
        if (!io_M_We && io_M_ByteEn != 4'h0) io_S_Data <= mem[io_M_Addr];
        else                                 io_S_Data <= $urandom;
    end

    always @(negedge clk) begin
        if (io_done === 1'b1) done_cnt++;
        if (io_M_We === 1'b1) begin
            wr_cnt++;
            if (io_M_ByteEn !== 4'hF) cmd_err++;
        end else if (io_M_ByteEn !== 4'h0) begin
            rd_cnt++;
            rd_addr_q.push_back(io_M_Addr);
            if (io_M_ByteEn !== 4'hF) cmd_err++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_copy(input logic [15:0] s, input logic [15:0] d, input int len);
        for (int i = 0; i < len; i++) ref_mem[16'(d + i)] = ref_mem[16'(s + i)];
    endtask

    task automatic mem_compare(input string tag);
        int diff = 0;
        for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) diff++;
        check(tag, diff, 0);
    endtask

    // Issue one start and follow the transfer to its done pulse.
    task automatic run(input string tag, input logic [15:0] s, input logic [15:0] d,
                       input int len, input int exp_lat, input int exp_wr,
                       input int exp_rd, input bit intrude);
        int wr0 = wr_cnt;
        int rd0 = rd_cnt;
        int dn0 = done_cnt;
        int ce0 = cmd_err;
        int lat;
        logic busy1;
        check({tag, "_idle_busy"}, io_busy, 1'b0);
        io_src   = s;
        io_dst   = d;
        io_len   = 16'(len);
        io_start = 1'b1;
        step();
        io_start = 1'b0;
        busy1 = io_busy;
        lat = 1;
        while (io_done !== 1'b1 && lat < 300) begin
            if (intrude && lat == 4) begin
                io_start = 1'b1;
                io_src   = s + 16'h0800;
                io_dst   = d + 16'h0800;
                io_len   = 16'd7;
            end else if (intrude && lat == 5) begin
                io_start = 1'b0;
            end
            step();
            lat++;
        end
        io_start = 1'b0;
        check({tag, "_busy"}, busy1, 1'b1);
        check({tag, "_lat"}, lat, exp_lat);
        step();
        check({tag, "_done_pulse"}, io_done, 1'b0);
        check({tag, "_busy_end"}, io_busy, 1'b0);
        repeat (4) step();
        check({tag, "_writes"}, wr_cnt - wr0, exp_wr);
        check({tag, "_reads"}, rd_cnt - rd0, exp_rd);
        check({tag, "_dones"}, done_cnt - dn0, 1);
        check({tag, "_cmd"}, cmd_err - ce0, 0);
    endtask

    initial begin
        int rd_base;
        int wes;
        int k;
        int w0;
        int d0;
        logic [15:0] s;
        logic [15:0] d;
        int len;

        for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);

        repeat (3) @(posedge clk);
        #2;
        check("rst_busy",   io_busy,     1'b0);
        check("rst_done",   io_done,     1'b0);
        check("rst_we",     io_M_We,     1'b0);
        check("rst_byteen", io_M_ByteEn, 4'h0);
        check("rst_addr",   io_M_Addr,   16'h0);
        check("rst_data",   io_M_Data,   32'h0);
        reset = 1'b1;
        repeat (2) step();

        run("basic", 16'h0010, 16'h0040, 4, 13, 4, 4, 1'b0);
        ref_copy(16'h0010, 16'h0040, 4);
        mem_compare("basic_mem");

        run("zero", 16'h1234, 16'h4321, 0, 1, 0, 0, 1'b0);
        mem_compare("zero_mem");

        rd_base = rd_addr_q.size();
        run("wrap", 16'hFFFE, 16'h0100, 3, 10, 3, 3, 1'b0);
        ref_copy(16'hFFFE, 16'h0100, 3);
        mem_compare("wrap_mem");
        check("wrap_rd0", rd_addr_q[rd_base + 0], 16'hFFFE);
        check("wrap_rd1", rd_addr_q[rd_base + 1], 16'hFFFF);
        check("wrap_rd2", rd_addr_q[rd_base + 2], 16'h0000);

        run("busy_start", 16'h0200, 16'h0300, 4, 13, 4, 4, 1'b1);
        ref_copy(16'h0200, 16'h0300, 4);
        mem_compare("busy_start_mem");

        // Asynchronous reset in the middle of the second write of an 8-word copy.
        w0 = wr_cnt;
        d0 = done_cnt;
        io_src   = 16'h5000;
        io_dst   = 16'h6000;
        io_len   = 16'd8;
        io_start = 1'b1;
        step();
        io_start = 1'b0;
        wes = 0;
        k = 0;
        while (wes < 2 && k < 40) begin
            step();
            k++;
            if (io_M_We === 1'b1) wes++;
        end
        check("arst_reach_wr2", wes, 2);
        #2 reset = 1'b0;
        #1;
        check("arst_busy",   io_busy,     1'b0);
        check("arst_done",   io_done,     1'b0);
        check("arst_we",     io_M_We,     1'b0);
        check("arst_byteen", io_M_ByteEn, 4'h0);
        check("arst_addr",   io_M_Addr,   16'h0);
        check("arst_data",   io_M_Data,   32'h0);
        #10 reset = 1'b1;
        repeat (10) step();
        check("arst_writes", wr_cnt - w0, 1);
        check("arst_dones",  done_cnt - d0, 0);
        check("arst_idle",   io_busy, 1'b0);
        ref_copy(16'h5000, 16'h6000, 1);
        mem_compare("arst_mem");

        for (int t = 0; t < 6; t++) begin
            s   = 16'($urandom);
            d   = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'(s + $urandom_range(1, 10));
            len = $urandom_range(1, 12);
            run("rand", s, d, len, 3 * len + 1, len, len, 1'b0);
            ref_copy(s, d, len);
            mem_compare("rand_mem");
        end

`ifdef SPM_COPY_FILL_EN
        io_fill    = 1'b1;
        io_pattern = 32'hDEAD_BEEF;
        run("fill", 16'h7777, 16'h0020, 5, 6, 5, 0, 1'b0);
        io_fill    = 1'b0;
        io_pattern = '0;
        for (int i = 0; i < 5; i++) ref_mem[16'h0020 + i] = 32'hDEAD_BEEF;
        mem_compare("fill_mem");
        run("after_fill", 16'h0020, 16'h0030, 2, 7, 2, 2, 1'b0);
        ref_copy(16'h0020, 16'h0030, 2);
        mem_compare("after_fill_mem");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
